// File: rtl/sort_mem_responder.sv
// Small word memory with a fixed-latency read/write handshake and a preload port.
// Each access sets one read or write in flight for LATENCY cycles, then pulses ready for one cycle.
//
//   state | meaning
//   IDLE  | waiting for a request; preload allowed when no request is present
//   BUSY  | request latched, latency counter running down
//   ACK   | access done on entry, ready high for this one cycle
module sort_mem_responder #(
  parameter int DW      = 8,
  parameter int AW      = 4,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          read,
  input  logic          write,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          busy,
  output logic          err
);

  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          op_wr_q, op_wr_d;
  logic [AW-1:0] addr_l_q, addr_l_d;
  logic [DW-1:0] wdata_l_q, wdata_l_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic          acc_en;
  logic          acc_wr;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    addr_l_d  = addr_l_q;
    wdata_l_d = wdata_l_q;
    err_d     = 1'b0;
    acc_en    = 1'b0;
    acc_wr    = op_wr_q;
    acc_addr  = addr_l_q;
    acc_wdata = wdata_l_q;

    case (state_q)
      IDLE: begin
        if (read ^ write) begin
          op_wr_d   = write;
          addr_l_d  = addr;
          wdata_l_d = wdata;
          cnt_d     = CNT_INIT;
          if (LATENCY == 1) begin
            // With single-cycle latency the access happens on the accepting
            // edge, so it must use the live inputs rather than the latches.
            state_d   = ACK;
            acc_en    = 1'b1;
            acc_wr    = write;
            acc_addr  = addr;
            acc_wdata = wdata;
          end else begin
            state_d = BUSY;
          end
        end else if (read && write) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d = ACK;
          acc_en  = 1'b1;
        end
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = acc_en;

    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (acc_en) begin
      if (acc_wr) mem_d[acc_addr] = acc_wdata;
      else        rdata_d = mem_q[acc_addr];
    end
    if (state_q == IDLE && !read && !write && ld_en) mem_d[ld_addr] = ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_wr_q   <= 1'b0;
      addr_l_q  <= '0;
      wdata_l_q <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      addr_l_q  <= addr_l_d;
      wdata_l_q <= wdata_l_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sort_mem_responder.sv
// Bench for sort_mem_responder: three builds (LATENCY 2, 1, 4) driven one at a time,
// checked against a plain array memory model with latency taken from the parameter.
module tb_sort_mem_responder;

  logic       clk;
  logic       rst;
  logic       read_a   [3];
  logic       write_a  [3];
  logic [3:0] addr_a   [3];
  logic [7:0] wdata_a  [3];
  logic       ld_en_a  [3];
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] rdata_a  [3];
  logic       ready_a  [3];
  logic       busy_a   [3];
  logic       err_a    [3];

  logic [7:0] mem_m   [3][16];
  logic [7:0] last_rd [3];
  int         n_checks;
  int         n_pass;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sort_mem_responder #(
      .DW(8), .AW(4), .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 4)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .read   (read_a[g]),
      .write  (write_a[g]),
      .addr   (addr_a[g]),
      .wdata  (wdata_a[g]),
      .ld_en  (ld_en_a[g]),
      .ld_addr(ld_addr),
      .ld_data(ld_data),
      .rdata  (rdata_a[g]),
      .ready  (ready_a[g]),
      .busy   (busy_a[g]),
      .err    (err_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(int s);
    return (s == 0) ? 2 : (s == 1) ? 1 : 4;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      last_rd[s] = 8'h00;
      for (int i = 0; i < 16; i++) mem_m[s][i] = 8'h00;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic do_acc(int s, bit wr, logic [3:0] a, logic [7:0] d, bit ld_busy);
    int  n, nb;
    bit  got;
    read_a[s]  = !wr;
    write_a[s] = wr;
    addr_a[s]  = a;
    wdata_a[s] = d;
    n = 0; nb = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      if (n == 1) begin
        #1;
        addr_a[s]  = 4'($urandom);
        wdata_a[s] = 8'($urandom);
        if (ld_busy) begin
          ld_en_a[s] = 1'b1;
          ld_addr    = 4'($urandom);
          ld_data    = 8'($urandom);
        end
      end
      @(negedge clk);
      if (busy_a[s]) nb++;
      if (ready_a[s]) got = 1;
    end
    chk($sformatf("ack_latency[%0d]", s), n, lat_of(s));
    chk($sformatf("busy_cycles[%0d]", s), nb, lat_of(s));
    if (wr) begin
      mem_m[s][a] = d;
      chk($sformatf("rdata_hold[%0d]", s), rdata_a[s], last_rd[s]);
    end else begin
      last_rd[s] = mem_m[s][a];
      chk($sformatf("rdata[%0d] a=%0d", s, a), rdata_a[s], mem_m[s][a]);
    end
    read_a[s]  = 1'b0;
    write_a[s] = 1'b0;
    ld_en_a[s] = 1'b0;
    @(negedge clk);
    chk($sformatf("ready_single[%0d]", s), ready_a[s], 1'b0);
    chk($sformatf("busy_idle[%0d]", s), busy_a[s], 1'b0);
  endtask

  task automatic do_ld(int s, logic [3:0] a, logic [7:0] d);
    ld_en_a[s] = 1'b1;
    ld_addr    = a;
    ld_data    = d;
    @(negedge clk);
    ld_en_a[s] = 1'b0;
    mem_m[s][a] = d;
  endtask

  task automatic do_err(int s);
    read_a[s]  = 1'b1;
    write_a[s] = 1'b1;
    addr_a[s]  = 4'($urandom);
    wdata_a[s] = 8'($urandom);
    @(negedge clk);
    chk($sformatf("err_pulse[%0d]", s), err_a[s], 1'b1);
    chk($sformatf("err_no_ready[%0d]", s), ready_a[s], 1'b0);
    chk($sformatf("err_idle[%0d]", s), busy_a[s], 1'b0);
    read_a[s]  = 1'b0;
    write_a[s] = 1'b0;
    @(negedge clk);
    chk($sformatf("err_single[%0d]", s), err_a[s], 1'b0);
  endtask

  initial begin
    int rd_seen;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    ld_addr  = '0;
    ld_data  = '0;
    for (int s = 0; s < 3; s++) begin
      read_a[s] = 1'b0; write_a[s] = 1'b0; addr_a[s] = '0;
      wdata_a[s] = '0; ld_en_a[s] = 1'b0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_rdata[%0d]", s), rdata_a[s], 8'h00);
      chk($sformatf("rst_ready[%0d]", s), ready_a[s], 1'b0);
      chk($sformatf("rst_busy[%0d]", s), busy_a[s], 1'b0);
      chk($sformatf("rst_err[%0d]", s), err_a[s], 1'b0);
    end
    rst = 1'b0;

    // Reset contents, write/read back, illegal request.
    do_acc(0, 0, 4'd5, 8'h00, 0);
    do_acc(0, 1, 4'd3, 8'hA5, 0);
    do_acc(0, 0, 4'd3, 8'h00, 0);
    do_err(0);
    do_acc(0, 0, 4'd3, 8'h00, 0);

    // Descending preload, then one compare-and-swap step on words 0/1.
    for (int i = 0; i < 16; i++) do_ld(0, 4'(i), 8'(15 - i));
    do_acc(0, 0, 4'd0, 8'h00, 0);
    do_acc(0, 0, 4'd1, 8'h00, 0);
    if (mem_m[0][0] > mem_m[0][1]) begin
      logic [7:0] t0, t1;
      t0 = mem_m[0][0];
      t1 = mem_m[0][1];
      do_acc(0, 1, 4'd0, t1, 0);
      do_acc(0, 1, 4'd1, t0, 0);
    end
    do_acc(0, 0, 4'd0, 8'h00, 0);
    do_acc(0, 0, 4'd1, 8'h00, 0);

    // Preload attempted while busy must be dropped.
    do_acc(0, 0, 4'd2, 8'h00, 1);
    for (int i = 0; i < 16; i++) do_acc(0, 0, 4'(i), 8'h00, 0);

    // Reset in the middle of a write.
    write_a[0] = 1'b1;
    addr_a[0]  = 4'd7;
    wdata_a[0] = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", busy_a[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("busy_async_rst", busy_a[0], 1'b0);
    write_a[0] = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rd_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready_a[0]) rd_seen++;
    end
    chk("no_ready_after_rst", rd_seen, 0);
    do_acc(0, 0, 4'd7, 8'h00, 0);

    // Randomized traffic on every build.
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 60; k++) begin
        int op;
        op = int'($urandom_range(0, 9));
        if (op < 4)      do_acc(s, 0, 4'($urandom), 8'h00, bit'($urandom_range(0, 1)));
        else if (op < 7) do_acc(s, 1, 4'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
        else if (op < 9) do_ld(s, 4'($urandom), 8'($urandom));
        else             do_err(s);
      end
      for (int i = 0; i < 16; i++) do_acc(s, 0, 4'(i), 8'h00, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sort_mem_responder.md
SORT_MEM_RESPONDER -- requirements
Module: sort_mem_responder

Interface
REQ-001 Parameters: DW, default 8, data word width; AW, default 4, address width (2**AW words); LATENCY, default 2, cycles from request acceptance to ready (legal range 1..15).
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 read  in  1  read request, level; held by the initiator until it samples ready.
REQ-005 write  in  1  write request, level; held by the initiator until it samples ready.
REQ-006 addr  in  AW  word address of the request.
REQ-007 wdata  in  DW  write data.
REQ-008 ld_en  in  1  preload strobe, for test and initialisation.
REQ-009 ld_addr  in  AW  preload address.
REQ-010 ld_data  in  DW  preload data.
REQ-011 rdata  out  DW  read data, registered.
REQ-012 ready  out  1  one-cycle completion pulse, registered.
REQ-013 busy  out  1  high while a request is in flight (BUSY or ACK).
REQ-014 err  out  1  one-cycle pulse on an illegal request.

Function
REQ-015 Storage: 2**AW words of DW bits.
REQ-016 FSM states: IDLE, BUSY, ACK.
REQ-017 IDLE, read XOR write high at an edge: accept; latch op, addr, wdata; load cnt = LATENCY-1; go to BUSY, or to ACK if LATENCY = 1.
REQ-018 IDLE, read AND write high at an edge: no access; err=1 in the following cycle; stay in IDLE.
REQ-019 BUSY: decrement cnt each edge; go to ACK on the edge where cnt = 1, or when cnt = 0 at entry.
REQ-020 Access timing: the latched access executes on the edge entering ACK.
  - Read: mem[addr_l] -> rdata.
  - Write: wdata_l -> mem[addr_l].
REQ-021 ACK: ready=1 for exactly one cycle; next state IDLE unconditionally.
REQ-022 Acceptance-to-ready timing: with acceptance at edge E0, ready is high in the cycle between E0+LATENCY-1 and E0+LATENCY (exactly LATENCY cycles after acceptance).
REQ-023 Request sampling: addr, wdata and read/write are sampled only at acceptance; changes during BUSY/ACK are ignored.
REQ-024 A request held through ACK is re-accepted on the edge leaving ACK only if still asserted in the following IDLE cycle; the back-to-back minimum spacing is LATENCY+1 cycles per access.
REQ-025 rdata holds its value until the next read completes; writes do not change rdata.
REQ-026 Preload writes ld_data -> mem[ld_addr] on the edge only when state = IDLE, read = 0 and write = 0; otherwise it is ignored silently.
REQ-027 Read after write to the same address returns the new data.
REQ-028 busy=1 in BUSY and ACK, 0 in IDLE.

Reset
REQ-029 rst=1 forces IDLE immediately, regardless of clk.
REQ-030 Reset values: cnt=0, rdata=0, ready=0, busy=0, err=0, all memory words=0.
REQ-031 A request in flight at reset is discarded: no write commits, and no ready is issued after reset release.
REQ-032 First acceptance is possible at the first edge after rst deasserts.

Verification
REQ-033 Reset, then read addr 5 held (LATENCY=2): ready high exactly 2 cycles after the acceptance edge; rdata=0x00.
REQ-034 Write addr 3 data 0xA5 until ready, then read addr 3: rdata=0xA5 in the read's ready cycle; busy high for 2 cycles per access.
REQ-035 Preload addr 0..15 with 15..0, then perform a bubble-sort style read-read-write-write sequence on addr 0/1: mem[0]=14, mem[1]=15; each ready is single-cycle.
REQ-036 read=write=1 in IDLE: err pulses 1 cycle, no ready, memory unchanged; ld_en during BUSY: no memory change.
REQ-037 Assert rst in BUSY of a write of 0x3C to addr 7: ready never rises, mem[7]=0, state IDLE.
REQ-038 Rebuild with LATENCY=1 and LATENCY=4: ready-to-acceptance spacing is 1 and 4 cycles respectively; addr changed mid-BUSY has no effect.
